// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory port and
// hands instructions to decode over valid/ready, with branch/jump redirect.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imemReq,
  output logic [31:0]          imemAddr,
  input  logic                 imemAck,
  input  logic [31:0]          imemData,
  output logic                 instValid,
  input  logic                 instReady,
  output logic [31:0]          instr,
  output logic [5:0]           opCode,
  output logic [31:0]          pcOut,
  input  logic                 branchTaken,
  input  logic [31:0]          branchTarget,
  input  logic                 jump,
  input  logic [31:0]          jumpTarget,
  output logic [CNT_WIDTH-1:0] fetchCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } fetchState_t;

  fetchState_t    state;
  logic [31:0]    pc;
  logic           pending;
  logic [31:0]    pendTarget;
  logic           redir;
  logic [31:0]    target;
  logic [31:0]    pcInc;
  logic [31:0]    fetchRedirTarget;

  // Branch wins over jump; targets are forced to word alignment.
  assign redir            = branchTaken | jump;
  assign target           = {(branchTaken ? branchTarget[31:2] : jumpTarget[31:2]), 2'b00};
  assign pcInc            = pc + 32'd4;
  assign fetchRedirTarget = redir ? target : pendTarget;

  // Fetch sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imemReq    <= 1'b0;
      imemAddr   <= RESET_PC;
      instValid  <= 1'b0;
      instr      <= 32'h0000_0000;
      opCode     <= 6'b00_0000;
      pcOut      <= 32'h0000_0000;
      fetchCount <= {CNT_WIDTH{1'b0}};
      pending    <= 1'b0;
      pendTarget <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          imemReq <= 1'b1;
          if (redir) begin
            pc       <= target;
            imemAddr <= target;
          end else begin
            imemAddr <= pc;
          end
        end
        FETCH: begin
          if (imemAck) begin
            if (redir || pending) begin
              // Returned word belongs to the abandoned path: drop it and refetch.
              pc       <= fetchRedirTarget;
              imemAddr <= fetchRedirTarget;
              pending  <= 1'b0;
            end else begin
              instr     <= imemData;
              opCode    <= imemData[31:26];
              pcOut     <= pc;
              instValid <= 1'b1;
              pc        <= pcInc;
              imemAddr  <= pcInc;
              imemReq   <= 1'b0;
              state     <= HOLD;
            end
          end else if (redir) begin
            // Request must stay stable, so remember where to go once it lands.
            pending    <= 1'b1;
            pendTarget <= target;
          end else begin
            pending <= pending;
          end
        end
        HOLD: begin
          if (redir) begin
            instValid <= 1'b0;
            pc        <= target;
            imemAddr  <= target;
            imemReq   <= 1'b1;
            state     <= FETCH;
            if (instReady) begin
              fetchCount <= fetchCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
              fetchCount <= fetchCount;
            end
          end else if (instReady) begin
            instValid  <= 1'b0;
            fetchCount <= fetchCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            imemAddr   <= pc;
            imemReq    <= 1'b1;
            state      <= FETCH;
          end else begin
            instValid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          imemReq   <= 1'b0;
          instValid <= 1'b0;
          pending   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by
// randomized traffic, all checked against a transaction-level fetch model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq, imemAck, instValid, instReady;
  logic [31:0] imemAddr, imemData, instr, pcOut;
  logic [5:0]  opCode;
  logic        branchTaken, jump;
  logic [31:0] branchTarget, jumpTarget;
  logic [15:0] fetchCount;

  logic        imemReq2, instValid2;
  logic [31:0] imemAddr2, imemData2, instr2, pcOut2;
  logic [5:0]  opCode2;
  logic [15:0] fetchCount2;
  logic        one = 1'b1;
  logic        zero = 1'b0;
  logic [31:0] zero32 = 32'h0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: memWord = 32'h8C00_0000;
      32'h0000_0004: memWord = 32'hAC00_0000;
      32'h0000_0008: memWord = 32'h1000_0000;
      default:       memWord = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  assign imemData  = memWord(imemAddr);
  assign imemData2 = memWord(imemAddr2);

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData), .instValid(instValid),
    .instReady(instReady), .instr(instr), .opCode(opCode), .pcOut(pcOut),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .jump(jump),
    .jumpTarget(jumpTarget), .fetchCount(fetchCount)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_WIDTH(16)) dutWrap (
    .clk(clk), .rst_n(rst_n), .imemReq(imemReq2), .imemAddr(imemAddr2),
    .imemAck(one), .imemData(imemData2), .instValid(instValid2),
    .instReady(one), .instr(instr2), .opCode(opCode2), .pcOut(pcOut2),
    .branchTaken(zero), .branchTarget(zero32), .jump(zero),
    .jumpTarget(zero32), .fetchCount(fetchCount2)
  );

  // Reference model: what the fetch stage should be showing the outside world.
  // phase: 0 = just out of reset, 1 = request outstanding, 2 = instruction presented
  int          mPhase;
  logic [31:0] mAddr, mInstr, mPcOut, mPendT;
  bit          mReq, mValid, mPend;
  int          mCount;

  task automatic modelReset();
    mPhase = 0; mAddr = 32'h0; mInstr = 32'h0; mPcOut = 32'h0;
    mReq = 1'b0; mValid = 1'b0; mPend = 1'b0; mPendT = 32'h0; mCount = 0;
  endtask

  task automatic modelStep(input bit a, input bit r, input bit b, input logic [31:0] bt,
                           input bit j, input logic [31:0] jt);
    bit          redirect;
    logic [31:0] tgt;
    redirect = b | j;
    tgt = (b ? bt : jt) & 32'hFFFF_FFFC;
    if (mPhase == 0) begin
      if (redirect) mAddr = tgt;
      mReq = 1'b1;
      mPhase = 1;
    end else if (mPhase == 1) begin
      if (a && (redirect || mPend)) begin
        mAddr = redirect ? tgt : mPendT;
        mPend = 1'b0;
      end else if (a) begin
        mInstr = memWord(mAddr);
        mPcOut = mAddr;
        mValid = 1'b1;
        mReq = 1'b0;
        mAddr = mAddr + 32'd4;
        mPhase = 2;
      end else if (redirect) begin
        mPend = 1'b1;
        mPendT = tgt;
      end
    end else begin
      if (redirect || r) begin
        if (r) mCount = (mCount + 1) % 65536;
        if (redirect) mAddr = tgt;
        mValid = 1'b0;
        mReq = 1'b1;
        mPhase = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    chk("imemReq", {31'h0, imemReq}, {31'h0, mReq});
    if (mReq) chk("imemAddr", imemAddr, mAddr);
    chk("instValid", {31'h0, instValid}, {31'h0, mValid});
    if (mValid) begin
      chk("instr", instr, mInstr);
      chk("opCode", {26'h0, opCode}, {26'h0, mInstr[31:26]});
      chk("pcOut", pcOut, mPcOut);
    end
    chk("fetchCount", {16'h0, fetchCount}, mCount[31:0]);
  endtask

  // Drive one cycle of inputs (at a negedge), advance the model, check at next negedge.
  task automatic cyc(input bit a, input bit r, input bit b, input logic [31:0] bt,
                     input bit j, input logic [31:0] jt);
    imemAck = a; instReady = r; branchTaken = b; branchTarget = bt;
    jump = j; jumpTarget = jt;
    modelStep(a, r, b, bt, j, jt);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    rst_n = 1'b0; imemAck = 1'b1; instReady = 1'b1;
    branchTaken = 1'b0; jump = 1'b0; branchTarget = 32'h0; jumpTarget = 32'h0;
    modelReset();
    repeat (2) @(negedge clk);
    chk("rst_imemAddr", imemAddr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opCode", {26'h0, opCode}, 32'h0);
    chk("rst_pcOut", pcOut, 32'h0);
    chk("rst_wrapAddr", imemAddr2, 32'hFFFF_FFFC);
    checkAll();
    rst_n = 1'b1;

    // Zero-wait memory, decoder always ready; ack during IDLE is ignored.
    cyc(1, 1, 0, 0, 0, 0);
    chk("wrap_first", imemAddr2, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0, 0, 0);
    chk("op_lw", {26'h0, opCode}, {26'h0, 6'b100011});
    cyc(1, 1, 0, 0, 0, 0);
    chk("wrap_second", imemAddr2, 32'h0000_0000);
    chk("wrap_req", {31'h0, imemReq2}, 32'h1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("op_sw", {26'h0, opCode}, {26'h0, 6'b101011});
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("op_beq", {26'h0, opCode}, {26'h0, 6'b000100});
    cyc(1, 1, 0, 0, 0, 0);
    chk("count3", {16'h0, fetchCount}, 32'd3);

    // Backpressure in HOLD for 5 cycles, then exactly one handshake.
    cyc(1, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("bp_count", {16'h0, fetchCount}, 32'd4);

    // Redirect while a fetch at 0x10 is outstanding; ack arrives 3 cycles later.
    chk("outst_addr", imemAddr, 32'h10);
    cyc(0, 0, 1, 32'h23, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("outst_hold", imemAddr, 32'h10);
    cyc(1, 0, 0, 0, 0, 0);
    chk("outst_new", imemAddr, 32'h20);
    chk("outst_nopres", {31'h0, instValid}, 32'h0);

    // Jump while presenting 0x20 without ready.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h40);
    chk("jmp_addr", imemAddr, 32'h40);
    chk("jmp_count", {16'h0, fetchCount}, 32'd4);

    // Simultaneous branch and jump: branch wins, both during fetch and in HOLD.
    cyc(0, 0, 1, 32'h100, 1, 32'h200);
    cyc(1, 0, 0, 0, 0, 0);
    chk("prio_fetch", imemAddr, 32'h100);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h300, 1, 32'h400);
    chk("prio_hold", imemAddr, 32'h300);
    chk("redir_ready_cnt", {16'h0, fetchCount}, 32'd5);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0), $urandom,
          ($urandom_range(0, 15) == 0), $urandom);
    end

    // Fresh reset, run to a counted handshake and an outstanding fetch, then abort.
    rst_n = 1'b0;
    #1;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("pre_abort_cnt", {16'h0, fetchCount}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req", {31'h0, imemReq}, 32'h0);
    chk("abort_valid", {31'h0, instValid}, 32'h0);
    chk("abort_count", {16'h0, fetchCount}, 32'h0);
    chk("abort_addr", imemAddr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
